// File: rtl/rom_fetch_sequencer.sv
// rtl/rom_fetch_sequencer.sv - TD4 instruction fetch sequencer: PC, instruction register, run/step/halt control
module rom_fetch_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       HALT_REQ,
    input  logic       JMP,
    input  logic [3:0] JMP_ADDR,
    output logic [3:0] ADDRESS,
    input  logic [3:0] OP_CODE,
    input  logic [3:0] ROM_DATA,
    output logic [3:0] IR_OP,
    output logic [3:0] IR_IMM,
    output logic       IR_VALID,
    output logic       BUSY,
    output logic       HALTED,
    output logic       WRAP,
    output logic [7:0] ISSUE_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [3:0]  ir_op_q, ir_op_d;
    logic [3:0]  ir_imm_q, ir_imm_d;
    logic        step_q, step_d;
    logic        wrap_q, wrap_d;
    logic [7:0]  cnt_q, cnt_d;

    // Next-state logic: sequencing, PC update, IR capture and issue counting
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_op_d  = ir_op_q;
        ir_imm_d = ir_imm_q;
        step_d   = step_q;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                // RUN has priority; a step request only latches when RUN is low
                if (RUN) begin
                    state_d = FETCH;
                    step_d  = 1'b0;
                end else if (STEP) begin
                    state_d = FETCH;
                    step_d  = 1'b1;
                end
            end
            FETCH: begin
                // ROM is combinational from ADDRESS, so the word is ready this cycle
                ir_op_d  = OP_CODE;
                ir_imm_d = ROM_DATA;
                state_d  = ISSUE;
            end
            ISSUE: begin
                pc_d   = JMP ? JMP_ADDR : pc_q + 4'd1;
                wrap_d = !JMP && (pc_q == 4'hF);
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                step_d = 1'b0;
                if (HALT_REQ) begin
                    state_d = HALT;
                end else if (step_q) begin
                    state_d = IDLE;
                end else if (RUN) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                // Only reset leaves HALT; everything stays frozen
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            pc_q     <= 4'd0;
            ir_op_q  <= 4'd0;
            ir_imm_q <= 4'd0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_op_q  <= ir_op_d;
            ir_imm_q <= ir_imm_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ADDRESS   = pc_q;
    assign IR_OP     = ir_op_q;
    assign IR_IMM    = ir_imm_q;
    assign IR_VALID  = (state_q == ISSUE);
    assign BUSY      = (state_q == FETCH) || (state_q == ISSUE);
    assign HALTED    = (state_q == HALT);
    assign WRAP      = wrap_q;
    assign ISSUE_CNT = cnt_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb/tb_rom_fetch_sequencer.sv - scoreboard bench for rom_fetch_sequencer against a transaction-level model
module tb_rom_fetch_sequencer;

    logic       CLK;
    logic       RESET;
    logic       RUN;
    logic       STEP;
    logic       HALT_REQ;
    logic       JMP;
    logic [3:0] JMP_ADDR;
    logic [3:0] ADDRESS;
    logic [3:0] OP_CODE;
    logic [3:0] ROM_DATA;
    logic [3:0] IR_OP;
    logic [3:0] IR_IMM;
    logic       IR_VALID;
    logic       BUSY;
    logic       HALTED;
    logic       WRAP;
    logic [7:0] ISSUE_CNT;

    logic [7:0] rom [16];

    rom_fetch_sequencer dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .HALT_REQ(HALT_REQ),
        .JMP(JMP), .JMP_ADDR(JMP_ADDR), .ADDRESS(ADDRESS), .OP_CODE(OP_CODE),
        .ROM_DATA(ROM_DATA), .IR_OP(IR_OP), .IR_IMM(IR_IMM), .IR_VALID(IR_VALID),
        .BUSY(BUSY), .HALTED(HALTED), .WRAP(WRAP), .ISSUE_CNT(ISSUE_CNT)
    );

    assign OP_CODE  = rom[ADDRESS][7:4];
    assign ROM_DATA = rom[ADDRESS][3:0];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int op;
        int imm;
        int cnt;
        int next_pc;
        int wrap;
        int halt;
    } item_t;

    item_t exp_q[$];
    item_t pend;
    bit    pend_v = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    m_pc = 0;
    int    m_cnt = 0;

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    endtask

    // Monitor: compare every issue slot and the cycle following it
    always @(negedge CLK) begin
        if (pend_v) begin
            chk("next_address", ADDRESS, pend.next_pc);
            chk("wrap_after_issue", WRAP, pend.wrap);
            chk("cnt_after_issue", ISSUE_CNT, (pend.cnt == 255) ? 255 : pend.cnt + 1);
            chk("halted_after_issue", HALTED, pend.halt);
            pend_v = 0;
        end else begin
            chk("wrap_quiet", WRAP, 0);
        end
        if (IR_VALID) begin
            chk("issue_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                pend = exp_q.pop_front();
                chk("issue_address", ADDRESS, pend.pc);
                chk("ir_op", IR_OP, pend.op);
                chk("ir_imm", IR_IMM, pend.imm);
                chk("issue_cnt", ISSUE_CNT, pend.cnt);
                chk("busy_in_issue", BUSY, 1);
                pend_v = 1;
            end
        end
    end

    // Reference model: one instruction issue per call, expressed as PC/count arithmetic
    task automatic push_expect(input bit jmp, input logic [3:0] ja, input bit halt);
        item_t it;
        it.pc      = m_pc;
        it.op      = int'(rom[m_pc][7:4]);
        it.imm     = int'(rom[m_pc][3:0]);
        it.cnt     = m_cnt;
        it.next_pc = jmp ? int'(ja) : (m_pc + 1) % 16;
        it.wrap    = (!jmp && m_pc == 15) ? 1 : 0;
        it.halt    = halt ? 1 : 0;
        exp_q.push_back(it);
        m_pc  = it.next_pc;
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    endtask

    task automatic drive_issue(input bit jmp, input logic [3:0] ja, input bit halt,
                               input bit run_next, output int waits);
        bit found;
        found = 0;
        waits = 0;
        while (!found && waits < 8) begin
            @(posedge CLK); #1;
            waits++;
            if (IR_VALID) found = 1;
        end
        chk("issue_timeout", int'(found), 1);
        JMP      = jmp;
        JMP_ADDR = ja;
        HALT_REQ = halt;
        RUN      = run_next;
        STEP     = 1'b0;
        @(posedge CLK); #1;
        // Junk on the ISSUE-only inputs; must be ignored outside ISSUE
        JMP      = 1'($urandom_range(0, 1));
        JMP_ADDR = 4'($urandom_range(0, 15));
        HALT_REQ = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_issue(input bit jmp, input logic [3:0] ja, input bit halt,
                                input bit run_next, output int waits);
        push_expect(jmp, ja, halt);
        drive_issue(jmp, ja, halt, run_next, waits);
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        RESET = 1'b1;
        #4;
        RESET = 1'b0;
        m_pc  = 0;
        m_cnt = 0;
        @(posedge CLK); #1;
    endtask

    task automatic settle_idle();
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_busy", BUSY, 0);
        chk("idle_address", ADDRESS, m_pc);
        chk("idle_cnt", ISSUE_CNT, m_cnt);
    endtask

    initial begin
        int  w;
        bit  j;
        bit  h;
        logic [3:0] ja;

        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
        rom[0] = 8'h5C;
        RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0; JMP = 1'b0; JMP_ADDR = 4'd0;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_address", ADDRESS, 0);
        chk("rst_ir_op", IR_OP, 0);
        chk("rst_ir_imm", IR_IMM, 0);
        chk("rst_ir_valid", IR_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_halted", HALTED, 0);
        chk("rst_wrap", WRAP, 0);
        chk("rst_cnt", ISSUE_CNT, 0);
        RESET = 1'b0;

        // Free run over the whole ROM, one issue every two cycles
        RUN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            expect_issue(1'b0, 4'd0, 1'b0, k < 15, w);
            chk("run_latency", w, (k == 0) ? 2 : 1);
        end
        settle_idle();
        chk("cnt_16", ISSUE_CNT, 16);

        // Jump at PC=3 to 0xA, then jump 15 -> 0 without WRAP
        RUN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            j  = (m_pc == 3) || (m_pc == 15);
            ja = (m_pc == 3) ? 4'hA : 4'h0;
            expect_issue(j, ja, 1'b0, k < 9, w);
        end
        settle_idle();

        // RUN and STEP together: RUN wins, so no step stop; then RUN drops in FETCH
        RUN = 1'b1; STEP = 1'b1;
        expect_issue(1'b0, 4'd0, 1'b0, 1'b1, w);
        expect_issue(1'b0, 4'd0, 1'b0, 1'b1, w);
        chk("run_beats_step", w, 1);
        RUN = 1'b0;
        expect_issue(1'b0, 4'd0, 1'b0, 1'b0, w);
        chk("run_drop_in_fetch", w, 1);
        settle_idle();

        // Random free run with random jumps
        RUN = 1'b1;
        for (int k = 0; k < 40; k++) begin
            j  = ($urandom_range(0, 3) == 0);
            ja = 4'($urandom_range(0, 15));
            expect_issue(j, ja, 1'b0, k < 39, w);
        end
        settle_idle();

        // Saturation of the issue counter
        RUN = 1'b1;
        for (int k = 0; k < 300; k++) begin
            j  = ($urandom_range(0, 7) == 0);
            ja = 4'($urandom_range(0, 15));
            expect_issue(j, ja, 1'b0, k < 299, w);
        end
        settle_idle();
        chk("cnt_saturated", ISSUE_CNT, 255);

        // Halt at PC=5, then RUN/STEP have no effect, then reset recovers
        do_reset();
        RUN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            h = (m_pc == 5);
            expect_issue(1'b0, 4'd0, h, 1'b1, w);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            STEP = 1'($urandom_range(0, 1));
        end
        STEP = 1'b0;
        chk("halt_held", HALTED, 1);
        chk("halt_pc", ADDRESS, 6);
        chk("halt_cnt", ISSUE_CNT, 6);
        chk("halt_busy", BUSY, 0);
        RUN = 1'b0;
        do_reset();
        chk("halt_reset_halted", HALTED, 0);
        chk("halt_reset_pc", ADDRESS, 0);

        // Single step, with a second STEP while in FETCH
        push_expect(1'b0, 4'd0, 1'b0);
        STEP = 1'b1;
        drive_issue(1'b0, 4'd0, 1'b0, 1'b0, w);
        chk("step_latency", w, 2);
        settle_idle();

        // Asynchronous reset in the middle of a FETCH cycle
        STEP = 1'b1;
        @(posedge CLK); #1;
        STEP = 1'b0;
        chk("mid_fetch_busy", BUSY, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_address", ADDRESS, 0);
        chk("async_ir_op", IR_OP, 0);
        chk("async_ir_imm", IR_IMM, 0);
        chk("async_busy", BUSY, 0);
        chk("async_cnt", ISSUE_CNT, 0);
        #2;
        RESET = 1'b0;
        m_pc  = 0;
        m_cnt = 0;
        settle_idle();

        repeat (2) @(posedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
